// File: rtl/dram_arbiter_pkg.sv
// Shared types and default widths for the two-requester DRAM port arbiter.
package dram_arbiter_pkg;

   typedef enum logic [1:0] {
      ArbIdle   = 2'd0,
      ArbGrant0 = 2'd1,
      ArbGrant1 = 2'd2,
      ArbTurn   = 2'd3
   } arb_state_e;

   localparam int unsigned DefAddrW      = 32;
   localparam int unsigned DefDataW      = 256;
   localparam int unsigned DefTimeoutCyc = 1024;

endpackage

// File: rtl/dram_arbiter_if.sv
// One cache-line request/response port; used for both requester and DRAM sides.
interface dram_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 256
);

   logic              cs;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   // master issues the transaction, slave completes it
   modport master (
      output cs, we, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  cs, we, addr, wdata,
      output rdata, ack
   );

endinterface

// File: rtl/dram_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not granted last time wins.
module dram_arbiter_rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_idx
);

   assign grant_valid = |req;
   assign grant_idx   = (&req) ? ~last : req[1];

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM port between the I-cache (m0) and D-cache (m1) with a
// round-robin FSM, a one-cycle turnaround between owners and a sticky watchdog.
module dram_arbiter
   import dram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = DefAddrW,
   parameter int unsigned DATA_W      = DefDataW,
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
   input  logic            clk,
   input  logic            rst,
   dram_arbiter_if.slave   m0,
   dram_arbiter_if.slave   m1,
   dram_arbiter_if.master  dram,
   output logic            timeout_err
);

   localparam int unsigned WdW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

   arb_state_e     state_q;
   logic           last_grant_q;
   logic [WdW-1:0] wd_cnt_q;
   logic           err_q;

   logic              pick_valid;
   logic              pick_idx;
   logic              granted;
   logic              own_idx;
   logic              own_cs;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   dram_arbiter_rr_pick2 u_pick (
      .req         ({m1.cs, m0.cs}),
      .last        (last_grant_q),
      .grant_valid (pick_valid),
      .grant_idx   (pick_idx)
   );

   assign granted     = (state_q == ArbGrant0) || (state_q == ArbGrant1);
   assign own_idx     = (state_q == ArbGrant1);
   assign own_cs      = own_idx ? m1.cs : m0.cs;
   assign timeout_err = err_q;

   // Priority inside a grant: ack, then watchdog expiry, then requester abort.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ArbIdle;
         last_grant_q <= 1'b1;
         wd_cnt_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         unique case (state_q)
            ArbIdle: begin
               if (pick_valid) begin
                  state_q      <= pick_idx ? ArbGrant1 : ArbGrant0;
                  last_grant_q <= pick_idx;
                  wd_cnt_q     <= '0;
               end
            end
            ArbGrant0, ArbGrant1: begin
               if (dram.ack) begin
                  state_q <= ArbTurn;
               end else if (wd_cnt_q == WdLast) begin
                  err_q   <= 1'b1;
                  state_q <= ArbTurn;
               end else if (!own_cs) begin
                  state_q <= ArbTurn;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 1'b1;
               end
            end
            ArbTurn: state_q <= ArbIdle;
            default: state_q <= ArbIdle;
         endcase
      end
   end

   always_comb begin
      sel_we    = own_idx ? m1.we    : m0.we;
      sel_addr  = own_idx ? m1.addr  : m0.addr;
      sel_wdata = own_idx ? m1.wdata : m0.wdata;

      dram.cs    = granted;
      dram.we    = granted & sel_we;
      dram.addr  = granted ? sel_addr  : '0;
      dram.wdata = granted ? sel_wdata : '0;

      m0.ack   = (state_q == ArbGrant0) & dram.ack;
      m1.ack   = (state_q == ArbGrant1) & dram.ack;
      m0.rdata = m0.ack ? dram.rdata : '0;
      m1.rdata = m1.ack ? dram.rdata : '0;
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Random requester/DRAM traffic checked cycle by cycle against a port-ownership model.
module tb_dram_arbiter;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 256;
   localparam int unsigned TO     = 8;
   localparam int          NCYCLE = 4000;

   logic clk = 1'b0;
   logic rst;
   logic timeout_err;

   always #5 clk = ~clk;

   dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
   dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
   dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dram_bus ();

   dram_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m0          (m0_bus),
      .m1          (m1_bus),
      .dram        (dram_bus),
      .timeout_err (timeout_err)
   );

   // Stimulus state
   bit          cs    [2];
   bit          we    [2];
   logic [AW-1:0] addr  [2];
   logic [DW-1:0] wdata [2];
   bit          d_ack;
   logic [DW-1:0] d_rdata;

   assign m0_bus.cs    = cs[0];
   assign m0_bus.we    = we[0];
   assign m0_bus.addr  = addr[0];
   assign m0_bus.wdata = wdata[0];
   assign m1_bus.cs    = cs[1];
   assign m1_bus.we    = we[1];
   assign m1_bus.addr  = addr[1];
   assign m1_bus.wdata = wdata[1];
   assign dram_bus.ack   = d_ack;
   assign dram_bus.rdata = d_rdata;

   // Reference model: who owns the port, for how long, and how many dead cycles remain
   int owner;
   int age;
   int blank;
   bit last;
   bit err_m;
   bit model_ok;
   bit ack_seen [2];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   task automatic check_eq(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic new_payload(input int i);
      we[i]    = $urandom_range(1, 0) == 1;
      addr[i]  = {$urandom} & 32'hFFFF_FFC0;
      wdata[i] = rand_line();
   endtask

   task automatic compare_outputs();
      bit            own;
      logic [DW-1:0] exp_rd;
      own = (owner >= 0);
      check_eq("dram_cs", dram_bus.cs, own);
      check_eq("dram_we", dram_bus.we, own ? we[owner] : 1'b0);
      check_eq("dram_addr", dram_bus.addr, own ? addr[owner] : '0);
      check_eq("dram_wdata", dram_bus.wdata, own ? wdata[owner] : '0);
      for (int i = 0; i < 2; i++) begin
         exp_rd = (owner == i && d_ack) ? d_rdata : '0;
         check_eq($sformatf("m%0d_ack", i), (i == 0) ? m0_bus.ack : m1_bus.ack,
                  owner == i && d_ack);
         check_eq($sformatf("m%0d_rdata", i), (i == 0) ? m0_bus.rdata : m1_bus.rdata,
                  exp_rd);
      end
      check_eq("timeout_err", timeout_err, err_m);
   endtask

   task automatic end_txn();
      owner = -1;
      blank = 1;
   endtask

   // Advance the model across the coming clock edge using the inputs now applied.
   task automatic model_step();
      if (!rst) begin
         owner    = -1;
         blank    = 0;
         last     = 1'b1;
         err_m    = 1'b0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         if (owner >= 0) begin
            if (d_ack) end_txn();
            else if (age == TO - 1) begin
               err_m = 1'b1;
               end_txn();
            end else if (!cs[owner]) end_txn();
            else age++;
         end else if (blank > 0) begin
            blank--;
         end else if (cs[0] || cs[1]) begin
            owner = (cs[0] && cs[1]) ? (last ? 0 : 1) : (cs[1] ? 1 : 0);
            last  = owner[0];
            age   = 0;
         end
      end
   endtask

   initial begin
      rst      = 1'b0;
      model_ok = 1'b0;
      owner    = -1;
      d_ack    = 1'b0;
      d_rdata  = '0;
      for (int i = 0; i < 2; i++) begin
         cs[i]       = 1'b0;
         ack_seen[i] = 1'b0;
         new_payload(i);
      end

      for (cyc = 0; cyc < NCYCLE; cyc++) begin
         @(negedge clk);
         if (model_ok) compare_outputs();
         for (int i = 0; i < 2; i++) ack_seen[i] = model_ok && owner == i && d_ack;
         model_step();

         @(posedge clk);
         #1;
         rst = !(cyc < 2 || $urandom_range(249, 0) == 0);
         // Alternate responsive and slow DRAM so the watchdog fires regularly.
         d_ack   = $urandom_range(((cyc / 500) % 2 == 1) ? 11 : 3, 0) == 0;
         d_rdata = rand_line();
         if (cyc == 2) begin
            cs[0] = 1'b1;
            cs[1] = 1'b1;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (cs[i]) begin
                  if (ack_seen[i]) begin
                     if ($urandom_range(1, 0) == 1) new_payload(i);
                     else cs[i] = 1'b0;
                  end else if ($urandom_range(39, 0) == 0) begin
                     cs[i] = 1'b0;
                  end
               end else if ($urandom_range(2, 0) == 0) begin
                  cs[i] = 1'b1;
                  new_payload(i);
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
